// File: rtl/octave_sequencer.sv
// Frame sequencer feeding the octave datapath: active pixels, H/V blanking pushes, then a bounded drain.
// Optional OCTAVE_SEQ_STALL_COUNT_EN adds a 24-bit count of ACTIVE cycles with no upstream pixel.
//
// state  | meaning
// IDLE   | waiting for start, no pushes
// ACTIVE | forwarding upstream pixels, stalls when none offered
// HBLANK | blanking pushes to the end of the line
// VBLANK | blanking pushes for the vertical blanking lines
// FLUSH  | blanking pushes until all frame outputs seen or drain limit hit
module octave_sequencer #(
  parameter int ACTIVE_W  = 400,
  parameter int TOTAL_W   = 420,
  parameter int ACTIVE_H  = 300,
  parameter int TOTAL_H   = 320,
  parameter int FLUSH_LEN = 2545
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [7:0]  oct_din,
  output logic        oct_validin,
  output logic        oct_blanking,
  input  logic        oct_valid,
  output logic        busy,
  output logic        frame_done,
  output logic        flush_err
`ifdef OCTAVE_SEQ_STALL_COUNT_EN
  ,
  output logic [23:0] stall_cnt
`endif
);

  localparam int CW = $clog2(TOTAL_W);
  localparam int RW = $clog2(TOTAL_H);
  localparam int FW = $clog2(FLUSH_LEN + 1);
  localparam logic [16:0] OUT_TARGET = 17'(ACTIVE_W * ACTIVE_H);

  typedef enum logic [2:0] {IDLE, ACTIVE, HBLANK, VBLANK, FLUSH} state_t;

  state_t         r_state, w_state_nxt;
  logic [CW-1:0]  r_col, w_col_nxt;
  logic [RW-1:0]  r_row, w_row_nxt;
  logic [FW-1:0]  r_flush_cnt, w_flush_nxt;
  logic [16:0]    r_out_cnt, w_out_nxt;
  logic           r_flush_err;
  logic           w_start_ok;
  logic           w_err_set;

  // Output-valid strobes in the exit cycle must count before the drain compare.
  assign w_out_nxt = (r_state != IDLE && oct_valid && r_out_cnt != OUT_TARGET)
                     ? r_out_cnt + 17'd1 : r_out_cnt;
  assign busy      = (r_state != IDLE);
  assign flush_err = r_flush_err;

  always_comb begin
    w_state_nxt  = r_state;
    w_col_nxt    = r_col;
    w_row_nxt    = r_row;
    w_flush_nxt  = r_flush_cnt;
    w_start_ok   = 1'b0;
    w_err_set    = 1'b0;
    pix_ready    = 1'b0;
    oct_validin  = 1'b0;
    oct_din      = '0;
    oct_blanking = 1'b0;
    frame_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_start_ok  = 1'b1;
          w_state_nxt = ACTIVE;
          w_col_nxt   = '0;
          w_row_nxt   = '0;
        end
      end
      ACTIVE: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          oct_validin = 1'b1;
          oct_din     = pix_data;
          w_col_nxt   = r_col + 1'b1;
          if (r_col == CW'(ACTIVE_W - 1)) w_state_nxt = HBLANK;
        end
      end
      HBLANK, VBLANK: begin
        oct_validin  = 1'b1;
        oct_blanking = 1'b1;
        if (r_col == CW'(TOTAL_W - 1)) begin
          w_col_nxt = '0;
          if (r_row == RW'(TOTAL_H - 1)) begin
            w_row_nxt   = '0;
            w_flush_nxt = '0;
            w_state_nxt = FLUSH;
          end else begin
            w_row_nxt   = r_row + 1'b1;
            w_state_nxt = (r_row < RW'(ACTIVE_H - 1)) ? ACTIVE : VBLANK;
          end
        end else begin
          w_col_nxt = r_col + 1'b1;
        end
      end
      FLUSH: begin
        oct_validin  = 1'b1;
        oct_blanking = 1'b1;
        w_flush_nxt  = r_flush_cnt + 1'b1;
        if (w_out_nxt == OUT_TARGET) begin
          frame_done  = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_flush_cnt == FW'(FLUSH_LEN - 1)) begin
          frame_done  = 1'b1;
          w_err_set   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_flush_cnt <= '0;
      r_out_cnt   <= '0;
      r_flush_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_flush_cnt <= w_flush_nxt;
      r_out_cnt   <= w_start_ok ? 17'd0 : w_out_nxt;
      r_flush_err <= w_start_ok ? 1'b0 : (r_flush_err | w_err_set);
    end
  end

`ifdef OCTAVE_SEQ_STALL_COUNT_EN
  logic [23:0] r_stall_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_start_ok) begin
      r_stall_cnt <= '0;
    end else if (r_state == ACTIVE && !pix_valid && r_stall_cnt != '1) begin
      r_stall_cnt <= r_stall_cnt + 24'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_octave_sequencer.sv
// Scoreboard bench for octave_sequencer on a scaled frame geometry; define
// OCTAVE_SEQ_STALL_COUNT_EN to also check the stall counter.
module tb_octave_sequencer;
  localparam int AW  = 8;
  localparam int TW  = 11;
  localparam int AH  = 4;
  localparam int TH  = 6;
  localparam int FL  = 20;
  localparam int LAT = 30;
  localparam int TGT = AW * AH;
  // blanking pushes between the last active pixel and the first FLUSH push
  localparam int BLANK_TAIL = (TW - AW) + (TH - AH) * TW;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] oct_din;
  logic       oct_validin;
  logic       oct_blanking;
  logic       oct_valid;
  logic       busy;
  logic       frame_done;
  logic       flush_err;
`ifdef OCTAVE_SEQ_STALL_COUNT_EN
  logic [23:0] stall_cnt;
`endif

  octave_sequencer #(
    .ACTIVE_W(AW), .TOTAL_W(TW), .ACTIVE_H(AH), .TOTAL_H(TH), .FLUSH_LEN(FL)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .oct_din(oct_din), .oct_validin(oct_validin), .oct_blanking(oct_blanking),
    .oct_valid(oct_valid), .busy(busy), .frame_done(frame_done),
    .flush_err(flush_err)
`ifdef OCTAVE_SEQ_STALL_COUNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  int           n_vec  = 0;
  int           n_miss = 0;
  logic [13:0]  exp_q[$];
  logic [LAT-1:0] dl;
  logic         ov_en;
  logic         m_err;
  int           m_out;
  int           fp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [13:0] mk(input logic rdy, input logic vin, input logic [7:0] din,
                                     input logic blk, input logic bsy, input logic done,
                                     input logic err);
    return {rdy, vin, din, blk, bsy, done, err};
  endfunction

  function automatic logic [13:0] obs_vec();
    return {pix_ready, oct_validin, oct_din, oct_blanking, busy, frame_done, flush_err};
  endfunction

  function automatic logic cur_ov();
    return ov_en & dl[LAT-1];
  endfunction

  // Datapath model: each active push returns oct_valid LAT cycles later.
  task automatic cyc(input logic pv, input logic [7:0] pd, input logic st,
                     input logic [13:0] e, input logic act_push);
    logic [13:0] want;
    pix_valid = pv;
    pix_data  = pd;
    start     = st;
    oct_valid = cur_ov();
    exp_q.push_back(e);
    @(negedge clock);
    want = exp_q.pop_front();
    chk("cycle", 32'(obs_vec()), 32'(want));
    @(posedge clock);
    #1;
    dl = {dl[LAT-2:0], act_push};
  endtask

  task automatic idle_cyc(input logic st);
    cyc(1'b0, 8'h00, st, mk(0, 0, 8'h00, 0, 0, 0, m_err), 1'b0);
  endtask

  task automatic do_abort();
    pix_valid = 1'b1;
    pix_data  = 8'h5a;
    start     = 1'b0;
    oct_valid = 1'b0;
    #2 reset = 1'b1;
    #1 chk("async_reset", 32'(obs_vec()), 32'd0);
    @(posedge clock);
    #1 chk("reset_hold", 32'(obs_vec()), 32'd0);
    @(negedge clock) reset = 1'b0;
    @(posedge clock);
    #1;
    dl    = '0;
    m_err = 1'b0;
  endtask

  task automatic run_frame(input int stall_after, input int stall_len, input logic ov_mode,
                           input int start_at, input logic start_on_done,
                           input int abort_row, input int abort_col, output int flush_pushes);
    int         pushes;
    logic [7:0] d;
    logic       done;
    pushes       = 0;
    flush_pushes = 0;
    dl           = '0;
    ov_en        = ov_mode;
    m_out        = 0;
    cyc(1'b0, 8'h00, 1'b1, mk(0, 0, 8'h00, 0, 0, 0, m_err), 1'b0);
    m_err = 1'b0;
    for (int r = 0; r < TH; r++) begin
      for (int c = 0; c < TW; c++) begin
        if (r < AH && c < AW) begin
          if (pushes == stall_after) begin
            for (int s = 0; s < stall_len; s++) begin
              m_out += int'(cur_ov());
              cyc(1'b0, 8'h00, 1'b0, mk(1, 0, 8'h00, 0, 1, 0, m_err), 1'b0);
            end
          end
          if (r == abort_row && c == abort_col) begin
            do_abort();
            return;
          end
          d = 8'($urandom);
          m_out += int'(cur_ov());
          cyc(1'b1, d, (pushes == start_at), mk(1, 1, d, 0, 1, 0, m_err), 1'b1);
          pushes++;
        end else begin
          d = 8'($urandom);
          m_out += int'(cur_ov());
          cyc(1'b1, d, 1'b0, mk(0, 1, 8'h00, 1, 1, 0, m_err), 1'b0);
        end
      end
    end
    done = 1'b0;
    while (!done && flush_pushes < FL) begin
      m_out += int'(cur_ov());
      done = (m_out >= TGT) || (flush_pushes == FL - 1);
      cyc(1'b0, 8'h00, done & start_on_done, mk(0, 1, 8'h00, 1, 1, done, m_err), 1'b0);
      flush_pushes++;
      if (done && m_out < TGT) m_err = 1'b1;
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    pix_valid = 1'b0;
    pix_data  = 8'h00;
    oct_valid = 1'b0;
    dl        = '0;
    ov_en     = 1'b0;
    m_err     = 1'b0;
    m_out     = 0;
    #12 chk("reset_outputs", 32'(obs_vec()), 32'd0);
    @(negedge clock) reset = 1'b0;
    @(posedge clock);
    #1;
    idle_cyc(1'b0);
    idle_cyc(1'b0);

    // normal frame; start mid-frame and on the done cycle must be ignored
    run_frame(-1, 0, 1'b1, 5, 1'b1, -1, -1, fp);
    chk("flush_len_normal", 32'(fp), 32'(LAT - BLANK_TAIL));
    idle_cyc(1'b0);

    // long upstream stall
    run_frame(13, 37, 1'b1, -1, 1'b0, -1, -1, fp);
    chk("flush_len_stall", 32'(fp), 32'(LAT - BLANK_TAIL));
`ifdef OCTAVE_SEQ_STALL_COUNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'd37);
`endif
    idle_cyc(1'b0);

    // datapath never answers: drain times out
    run_frame(-1, 0, 1'b0, -1, 1'b0, -1, -1, fp);
    chk("flush_len_timeout", 32'(fp), 32'(FL));
    idle_cyc(1'b0);
    idle_cyc(1'b0);

    // next accepted start clears the sticky error
    run_frame(-1, 0, 1'b1, -1, 1'b0, -1, -1, fp);
    chk("flush_len_recover", 32'(fp), 32'(LAT - BLANK_TAIL));
`ifdef OCTAVE_SEQ_STALL_COUNT_EN
    chk("stall_cnt_cleared", 32'(stall_cnt), 32'd0);
`endif
    idle_cyc(1'b0);

    // reset mid-line, then a fresh complete frame
    run_frame(-1, 0, 1'b1, -1, 1'b0, 2, 3, fp);
    idle_cyc(1'b0);
    run_frame(-1, 0, 1'b1, -1, 1'b0, -1, -1, fp);
    chk("flush_len_after_reset", 32'(fp), 32'(LAT - BLANK_TAIL));
    idle_cyc(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
